// File: rtl/bcd_arbiter.sv
// bcd_arbiter: round-robin sharing of one binary-to-BCD converter among CH_N channels; `define BCD_ARBITER_TIMEOUT_EN adds a WAIT watchdog
module bcd_arbiter #(
    parameter int CH_N    = 4,
    parameter int BCD_N   = 4,
    parameter int BIN_N   = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_N-1:0]         ch_req,
    input  logic [CH_N-1:0]         ch_sign,
    input  logic [CH_N*BIN_N-1:0]   ch_bin,
    output logic [CH_N-1:0]         ch_ack,
    output logic [CH_N-1:0]         ch_err,
    output logic [CH_N-1:0]         ch_valid,
    output logic [CH_N*BCD_N*4-1:0] ch_bcd,
    output logic                    busy,
    input  logic                    cvt_ready,
    input  logic                    cvt_done_tick,
    input  logic [BCD_N*4-1:0]      cvt_bcd,
    output logic                    cvt_start,
    output logic                    cvt_sign,
    output logic [BIN_N-1:0]        cvt_bin
);
    localparam int SW = $clog2(CH_N);
    localparam int DW = BCD_N * 4;
    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;
    state_t state, state_nx;
    logic [SW-1:0] last_grant, sel, pick, cand;
    logic [SW:0] wrap;
    logic found, grant, timeout;
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = grant ? START : IDLE;
            START:   state_nx = WAIT;
            WAIT:    state_nx = cvt_done_tick ? STORE : (timeout ? IDLE : WAIT);
            STORE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        cvt_start = state == START;
        busy      = state != IDLE;
        ch_ack    = (state == STORE) ? CH_N'(1) << sel : '0;
    end
    // search starts just after the last served channel, so it has lowest priority
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        wrap  = '0;
        cand  = '0;
        for (int i = 1; i <= CH_N; i++) begin
            wrap = {1'b0, last_grant} + (SW+1)'(i);
            cand = (wrap >= (SW+1)'(CH_N)) ? SW'(wrap - (SW+1)'(CH_N)) : SW'(wrap);
            if (!found && ch_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end
    assign grant = state == IDLE && cvt_ready && found;
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SW'(CH_N - 1);
            sel        <= '0;
            cvt_sign   <= 1'b0;
            cvt_bin    <= '0;
            ch_valid   <= '0;
            ch_bcd     <= '0;
        end else begin
            if (grant) begin
                sel      <= pick;
                cvt_sign <= ch_sign[pick];
                cvt_bin  <= ch_bin[pick*BIN_N +: BIN_N];
            end
            if (state == WAIT && cvt_done_tick) begin
                ch_bcd[sel*DW +: DW] <= cvt_bcd;
                ch_valid[sel]        <= 1'b1;
            end
            if (state == STORE || timeout) last_grant <= sel;
        end
    end
`ifdef BCD_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    assign timeout = state == WAIT && !cvt_done_tick && wd_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            ch_err <= '0;
        end else begin
            wd_cnt <= (state == WAIT && !cvt_done_tick && !timeout) ? wd_cnt + CW'(1) : '0;
            ch_err <= timeout ? CH_N'(1) << sel : '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign ch_err  = '0;
`endif
endmodule
